// File: rtl/byte_mux_scan_if.sv
// byte_mux_scan_if: channel inputs, valid/ready handshake and scan status of the byte selector
interface byte_mux_scan_if #(parameter int WIDTH = 8, parameter int N = 4);
  localparam int SELW = $clog2(N);
  logic [N*WIDTH-1:0] in_flat;
  logic [SELW-1:0] sel;
  logic mode;
  logic start;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [SELW-1:0] scan_idx;
  logic scan_done;
  modport master (
    output in_flat, sel, mode, start, in_valid, out_ready,
    input  in_ready, out_data, out_valid, scan_idx, scan_done
  );
  modport slave (
    input  in_flat, sel, mode, start, in_valid, out_ready,
    output in_ready, out_data, out_valid, scan_idx, scan_done
  );
endinterface

// File: rtl/byte_mux_scan.sv
// byte_mux_scan: registered N:1 word selector with direct and auto-scan modes and valid/ready flow control
module byte_mux_scan #(
  parameter int WIDTH = 8,
  parameter int N = 4
) (
  input logic clk,
  input logic rst_n,
  byte_mux_scan_if.slave bus
);
  localparam int SELW = $clog2(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);
  localparam logic [SELW:0] LAST_X = (SELW + 1)'(N - 1);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;
  logic [SELW-1:0] idx_q, idx_d, ch;
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, done_q, done_d, accept, last;
  logic [WIDTH-1:0] words [N];
  for (genvar g = 0; g < N; g++) begin : g_split
    assign words[g] = bus.in_flat[g*WIDTH +: WIDTH];
  end
  assign bus.in_ready = (!valid_q || bus.out_ready) && (state_q == SCAN || !bus.mode);
  assign accept = bus.in_valid && bus.in_ready;
  // out-of-range direct selects (only when N is not a power of two) clamp to the top channel
  assign ch = state_q == SCAN ? idx_q : ({1'b0, bus.sel} > LAST_X ? LAST : bus.sel);
  assign last = state_q == SCAN && idx_q == LAST;
  always_comb begin
    data_d = accept ? words[ch] : data_q;
    valid_d = accept || (valid_q && !bus.out_ready);
    done_d = accept && last;
    state_d = state_q == IDLE ? ((bus.mode && bus.start) ? SCAN : IDLE) : ((accept && last) ? IDLE : SCAN);
    idx_d = state_q == IDLE ? '0 : (accept ? (last ? '0 : idx_q + SELW'(1)) : idx_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
  assign bus.out_data = data_q;
  assign bus.out_valid = valid_q;
  assign bus.scan_idx = idx_q;
  assign bus.scan_done = done_q;
endmodule

// File: tb/tb_byte_mux_scan.sv
// tb_byte_mux_scan: drives an N=4 and an N=5 selector with shared stimulus against a queue-based reference model
module tb_byte_mux_scan;
  logic clk = 1'b0;
  logic rst_n;
  logic [39:0] in_flat;
  logic [2:0] sel;
  logic mode, start, in_valid, out_ready;
  int checks = 0;
  int errors = 0;
  byte_mux_scan_if #(.WIDTH(8), .N(4)) if4 ();
  byte_mux_scan_if #(.WIDTH(8), .N(5)) if5 ();
  byte_mux_scan #(.WIDTH(8), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  byte_mux_scan #(.WIDTH(8), .N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));
  always #5 clk = ~clk;
  assign if4.in_flat = in_flat[31:0];
  assign if4.sel = sel[1:0];
  assign if4.mode = mode;
  assign if4.start = start;
  assign if4.in_valid = in_valid;
  assign if4.out_ready = out_ready;
  assign if5.in_flat = in_flat;
  assign if5.sel = sel;
  assign if5.mode = mode;
  assign if5.start = start;
  assign if5.in_valid = in_valid;
  assign if5.out_ready = out_ready;
  logic rdy[2], ovalid[2], odone[2];
  logic [7:0] odata[2];
  logic [2:0] sidx[2];
  assign rdy[0] = if4.in_ready;
  assign rdy[1] = if5.in_ready;
  assign ovalid[0] = if4.out_valid;
  assign ovalid[1] = if5.out_valid;
  assign odone[0] = if4.scan_done;
  assign odone[1] = if5.scan_done;
  assign odata[0] = if4.out_data;
  assign odata[1] = if5.out_data;
  assign sidx[0] = {1'b0, if4.scan_idx};
  assign sidx[1] = if5.scan_idx;
  // reference model: a scan is the list of channels still to be delivered
  int nn[2] = '{4, 5};
  logic m_valid[2], m_done[2], acc[2];
  logic [7:0] m_data[2];
  int pend[2][$];
  task automatic chk(input string tag, input int u, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[n=%0d] got=%0h exp=%0h", tag, nn[u], got, exp);
    end
  endtask
  function automatic logic exp_rdy(input int u);
    return (!m_valid[u] || out_ready) && (pend[u].size() > 0 || !mode);
  endfunction
  function automatic int sel_of(input int u);
    return u == 0 ? int'(sel[1:0]) : int'(sel);
  endfunction
  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 1'b0;
      m_done[u] = 1'b0;
      m_data[u] = 8'h00;
      pend[u].delete();
    end
  endtask
  task automatic model_step(input int u);
    int c;
    bit scanning;
    scanning = pend[u].size() > 0;
    m_done[u] = 1'b0;
    if (acc[u]) begin
      c = scanning ? pend[u].pop_front() : (sel_of(u) > nn[u] - 1 ? nn[u] - 1 : sel_of(u));
      m_data[u] = 8'(in_flat >> (8 * c));
      m_valid[u] = 1'b1;
      if (scanning && pend[u].size() == 0) m_done[u] = 1'b1;
    end else if (out_ready) m_valid[u] = 1'b0;
    if (!scanning && mode && start)
      for (int i = 0; i < nn[u]; i++) pend[u].push_back(i);
  endtask
  task automatic chk_out(input int u);
    chk("out_valid", u, 32'(ovalid[u]), 32'(m_valid[u]));
    chk("out_data", u, 32'(odata[u]), 32'(m_data[u]));
    chk("scan_idx", u, 32'(sidx[u]), 32'(pend[u].size() > 0 ? nn[u] - pend[u].size() : 0));
    chk("scan_done", u, 32'(odone[u]), 32'(m_done[u]));
  endtask
  task automatic cycle();
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("in_ready", u, 32'(rdy[u]), 32'(exp_rdy(u)));
      acc[u] = in_valid && exp_rdy(u);
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) model_step(u);
    #1;
    for (int u = 0; u < 2; u++) chk_out(u);
    @(negedge clk);
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    for (int u = 0; u < 2; u++) chk_out(u);
    @(negedge clk);
    for (int u = 0; u < 2; u++) chk_out(u);
    rst_n = 1'b1;
  endtask
  task automatic drive(input logic [2:0] s, input logic m, input logic st, input logic v, input logic r);
    sel = s;
    mode = m;
    start = st;
    in_valid = v;
    out_ready = r;
  endtask
  logic [7:0] scan_exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  initial begin
    rst_n = 1'b0;
    in_flat = 40'hEE_DD_CC_BB_AA;
    drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) chk_out(u);
    rst_n = 1'b1;
    // direct select of channel 2
    drive(3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("t1_data", 0, 32'(odata[0]), 32'h0000_00CC);
    // back-to-back direct beats, no bubbles
    drive(3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("t2_data0", 0, 32'(odata[0]), 32'h0000_00AA);
    drive(3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("t2_data1", 0, 32'(odata[0]), 32'h0000_00BB);
    drive(3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("t2_data3", 0, 32'(odata[0]), 32'h0000_00DD);
    // backpressure: hold 0xBB while a sel=3 beat waits
    drive(3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    drive(3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold", 0, 32'(odata[0]), 32'h0000_00BB);
    end
    drive(3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("t3_take", 0, 32'(odata[0]), 32'h0000_00DD);
    // clamp: sel=7 on N=5 picks channel 4
    drive(3'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("t6_clamp", 1, 32'(odata[1]), 32'h0000_00EE);
    // scan with a stray start pulse mid-scan
    drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(3'd0, 1'b1, i == 1, 1'b1, 1'b1);
      cycle();
      chk("t4_scan", 0, 32'(odata[0]), 32'(scan_exp[i]));
    end
    chk("t4_done", 0, 32'(odone[0]), 32'h1);
    drive(3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    // reset two beats into a scan, then rescan from channel 0
    drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    drive(3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    cycle();
    async_reset();
    drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    drive(3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("t5_rescan", 0, 32'(odata[0]), 32'h0000_00AA);
    for (int i = 0; i < 5; i++) cycle();
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_flat = {8'($urandom), 32'($urandom)};
      drive(3'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) async_reset();
      else cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
